fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the dual-issue Program_Rom.
//  - Holds the program counter (PC, halfword index).
//  - Drives Rom_addr_in, pc_1, sel_mem_1 and sel_mem_0 so that IR_0 = instr[PC] and IR_1 = instr[PC+1].
//  - Qualifies both instructions with valid bits for the decoder.
//  - Advances the PC by the decoder's issue count; handles branch redirect, stall and end-of-program halt.
//  - Sits between the ROM and the decode/issue stage of the core.
// PARAMETERS
//  ADDR_W    14  ROM row address width; PC is ADDR_W+1 bits.
//  PROG_LEN  8   Number of valid halfword instructions; PC >= PROG_LEN is out of program.
//  RESET_PC  0   PC value loaded on reset.
// PORTS
//  clk          in   1         Core clock; all state updates on its rising edge.
//  rst          in   1         Synchronous, active-high reset.
//  Rom_addr_in  out  ADDR_W    ROM row = PC >> 1.
//  pc_1         out  1         PC[0]; selects row+1 for mem_0 when PC is odd.
//  sel_mem_1    out  1         IR_1 source: 1 = data_1 (PC even), 0 = data_0 (PC odd).
//  sel_mem_0    out  2         IR_0 source: 0 = data_0 (PC even), 2 = data_1 (PC odd). Value 1 is never driven.
//  ir0_valid    out  1         IR_0 holds instr[PC] and may issue.
//  ir1_valid    out  1         IR_1 holds instr[PC+1] and may issue.
//  pc           out  ADDR_W+1  Current PC, i.e. the address of IR_0.
//  issue_cnt    in   2         Instructions consumed this cycle (0, 1 or 2).
//  stall        in   1         Hold the PC; valids unchanged.
//  br_taken     in   1         Redirect request.
//  br_target    in   ADDR_W+1  Redirect halfword address.
//  halt_req     in   1         Software halt (e.g. BKPT decoded).
//  halted       out  1         Sequencer is in the HALT state.
//  perf_dual    out  32        Dual-issue cycle count (see CONFIGURATION).
//  perf_bubble  out  32        Flush-bubble count (see CONFIGURATION).
// BEHAVIOUR
//  Reset
//  - PC = RESET_PC, state = BOOT.
//  - ir0_valid = ir1_valid = 0, halted = 0, perf counters = 0.
//  - All ROM-select outputs are combinational from PC[0], with no latency:
//    - even PC: pc_1 = 0, sel_mem_1 = 1, sel_mem_0 = 0.
//    - odd PC:  pc_1 = 1, sel_mem_1 = 0, sel_mem_0 = 2.
//  States
//  - BOOT: one cycle with valids = 0, then -> RUN.
//  - RUN:
//    - ir0_valid = (PC < PROG_LEN); ir1_valid = (PC+1 < PROG_LEN).
//    - If !stall: PC <= PC + eff_cnt.
//    - eff_cnt = issue_cnt, except:
//      - issue_cnt == 3 is treated as 0.
//      - issue_cnt == 2 with ir1_valid = 0 is treated as 1.
//    - If PC + eff_cnt >= PROG_LEN -> HALT.
//  - FLUSH: entered on br_taken.
//    - PC <= br_target; valids = 0 for exactly one cycle; then -> RUN.
//    - If br_target >= PROG_LEN -> HALT instead.
//  - HALT:
//    - valids = 0, halted = 1, PC frozen.
//    - Exits only on rst.
//  Priority (same cycle)
//  - rst > halt_req > br_taken > stall > issue.
//  - br_taken ignores issue_cnt and stall.
//  - br_taken or issue_cnt while valids = 0 (BOOT/FLUSH/HALT) is ignored.
//  Wrap and reset
//  - PC arithmetic is ADDR_W+1 bits; overflow cannot occur because PROG_LEN <= 2^(ADDR_W+1) forces HALT first.
//  - rst asserted in any state returns to BOOT on the next edge.
// CONFIGURATION
//  Macro FETCH_PERF_CNT_EN.
//  - Defined:
//    - perf_dual increments each RUN cycle with !stall and eff_cnt == 2.
//    - perf_bubble increments each FLUSH cycle.
//    - Both counters are 32-bit, saturate at 2^32-1, and clear on rst.
//  - Undefined: ports remain present, tied to 0; no counter flops are synthesised.
// TESTING
//  1. rst for 2 cycles, then release:
//     -> cycle 1 valids = 0; cycle 2 PC = 0, Rom_addr_in = 0, sel_mem_0 = 0, sel_mem_1 = 1, valids = 1/1.
//  2. PROG_LEN = 8, issue_cnt = 2 every cycle:
//     -> PC 0, 2, 4, 6, then halted = 1; perf_dual = 4 (FETCH_PERF_CNT_EN defined).
//  3. issue_cnt = 1 from PC = 0:
//     -> PC = 1, Rom_addr_in = 0, pc_1 = 1, sel_mem_0 = 2, sel_mem_1 = 0.
//  4. br_taken with br_target = 5 while stall = 1:
//     -> next cycle valids = 0; following cycle PC = 5, Rom_addr_in = 2, valids = 1/1; perf_bubble = 1.
//  5. PC = 7, PROG_LEN = 8, issue_cnt = 2:
//     -> ir1_valid = 0, treated as 1, then HALT.
//     Separately, issue_cnt = 3 -> PC unchanged.
//  6. halt_req and br_taken in the same cycle -> HALT and PC frozen.
//     Then assert rst mid-HALT -> BOOT and PC = RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Program counter and fetch control for the dual-issue program ROM.
//   Addresses one ROM row per cycle and steers the two ROM data ports so that
//   IR_0 = instr[PC] and IR_1 = instr[PC+1]. Each instruction gets a valid bit.
//   The PC advances by the decoder's issue count. The block also handles branch
//   redirect (one bubble cycle), stall, and halt at end of program.
//
// Ports
//   clk, rst              core clock, synchronous active-high reset
//   Rom_addr_in           ROM row (PC >> 1)
//   pc_1                  PC[0]; mem_0 reads row+1 when PC is odd
//   sel_mem_1 / sel_mem_0 IR_1 / IR_0 source selects
//   ir0_valid, ir1_valid  instruction qualifiers for the decoder
//   pc                    current PC (address of IR_0)
//   issue_cnt, stall      decoder consumption and hold request
//   br_taken, br_target   redirect request and halfword target
//   halt_req              software halt
//   halted                sequencer is parked in HALT
//   perf_dual             dual-issue cycles
//   perf_bubble           flush bubbles
//
// Configuration
//   FETCH_PERF_CNT_EN  when defined, builds the two saturating perf counters.
//                      When undefined, the perf ports are tied to 0.

module fetch_sequencer #(
    parameter int ADDR_W   = 14,
    parameter int PROG_LEN = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] Rom_addr_in,
    output logic              pc_1,
    output logic              sel_mem_1,
    output logic [1:0]        sel_mem_0,
    output logic              ir0_valid,
    output logic              ir1_valid,
    output logic [ADDR_W:0]   pc,
    input  logic [1:0]        issue_cnt,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W:0]   br_target,
    input  logic              halt_req,
    output logic              halted,
    output logic [31:0]       perf_dual,
    output logic [31:0]       perf_bubble
);

    localparam int          PW   = ADDR_W + 1;
    localparam logic [31:0] PLEN = 32'(PROG_LEN);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH, ST_HALT} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [31:0]   pc_ext, pc_sum;
    logic [1:0]    eff_cnt;
    logic          br_go;

    // ROM steering depends only on PC parity, so it has no latency.
    assign pc          = pc_q;
    assign Rom_addr_in = pc_q[PW-1:1];
    assign pc_1        = pc_q[0];
    assign sel_mem_1   = ~pc_q[0];
    assign sel_mem_0   = pc_q[0] ? 2'd2 : 2'd0;

    assign pc_ext    = 32'(pc_q);
    assign ir0_valid = (state_q == ST_RUN) && (pc_ext < PLEN);
    assign ir1_valid = (state_q == ST_RUN) && ((pc_ext + 32'd1) < PLEN);
    assign halted    = (state_q == ST_HALT);

    // A branch only counts while an instruction is actually valid.
    assign br_go = br_taken && ir0_valid;

    // Count 3 is illegal and treated as 0. Dual issue past the program end
    // only consumes the one valid slot.
    always_comb begin
        eff_cnt = 2'd0;
        if (ir0_valid) begin
            case (issue_cnt)
                2'd1:    eff_cnt = 2'd1;
                2'd2:    eff_cnt = ir1_valid ? 2'd2 : 2'd1;
                default: eff_cnt = 2'd0;
            endcase
        end
    end

    assign pc_sum = pc_ext + 32'(eff_cnt);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_BOOT:  state_d = halt_req ? ST_HALT : ST_RUN;
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (br_go) begin
                    // An out-of-program target halts directly and keeps the PC.
                    if (32'(br_target) >= PLEN) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = br_target;
                        state_d = ST_FLUSH;
                    end
                end else if (!stall) begin
                    pc_d = pc_sum[PW-1:0];
                    if (pc_sum >= PLEN) state_d = ST_HALT;
                end
            end
            ST_FLUSH: state_d = halt_req ? ST_HALT : ST_RUN;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= PW'(RESET_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic dual_evt, bubble_evt;

    // Dual issue counts only when the issue really advances the PC.
    assign dual_evt   = (state_q == ST_RUN) && !halt_req && !br_go && !stall &&
                        (eff_cnt == 2'd2);
    assign bubble_evt = (state_q == ST_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dual   <= 32'd0;
            perf_bubble <= 32'd0;
        end else begin
            if (dual_evt && (perf_dual != 32'hFFFF_FFFF))
                perf_dual <= perf_dual + 32'd1;
            if (bubble_evt && (perf_bubble != 32'hFFFF_FFFF))
                perf_bubble <= perf_bubble + 32'd1;
        end
    end
`else
    assign perf_dual   = 32'd0;
    assign perf_bubble = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] Rom_addr_in;
    logic              pc_1, sel_mem_1;
    logic [1:0]        sel_mem_0;
    logic              ir0_valid, ir1_valid, halted;
    logic [ADDR_W:0]   pc;
    logic [1:0]        issue_cnt;
    logic              stall, br_taken, halt_req;
    logic [ADDR_W:0]   br_target;
    logic [31:0]       perf_dual, perf_bubble;

    int checks   = 0;
    int failures = 0;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_sequencer #(.ADDR_W(ADDR_W), .PROG_LEN(8), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .Rom_addr_in(Rom_addr_in), .pc_1(pc_1),
        .sel_mem_1(sel_mem_1), .sel_mem_0(sel_mem_0), .ir0_valid(ir0_valid),
        .ir1_valid(ir1_valid), .pc(pc), .issue_cnt(issue_cnt), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .halt_req(halt_req),
        .halted(halted), .perf_dual(perf_dual), .perf_bubble(perf_bubble)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_cnt = 2'd0; stall = 1'b0; br_taken = 1'b0;
        br_target = '0;   halt_req = 1'b0;
    endtask

    // Reset, then advance through BOOT into RUN at PC 0.
    task automatic reset_to_run();
        idle();
        rst = 1'b1; tick();
        rst = 1'b0; tick();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        chk("rst_pc",     32'(pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pdual",  perf_dual, 32'd0);
        chk("rst_pbub",   perf_bubble, 32'd0);
        rst = 1'b0;
        // BOOT cycle after release: valids low.
        chk("boot_v", {30'd0, ir0_valid, ir1_valid}, 32'd0);
        tick();
        chk("run_pc",   32'(pc), 32'd0);
        chk("run_addr", 32'(Rom_addr_in), 32'd0);
        chk("run_sel0", 32'(sel_mem_0), 32'd0);
        chk("run_sel1", 32'(sel_mem_1), 32'd1);
        chk("run_pc1",  32'(pc_1), 32'd0);
        chk("run_v",    {30'd0, ir0_valid, ir1_valid}, 32'd3);

        // Dual issue through the whole program.
        issue_cnt = 2'd2;
        tick(); chk("dual_pc2", 32'(pc), 32'd2);
        tick(); chk("dual_pc4", 32'(pc), 32'd4);
        tick(); chk("dual_pc6", 32'(pc), 32'd6);
        chk("dual_v6", {30'd0, ir0_valid, ir1_valid}, 32'd3);
        tick();
        chk("dual_halt",  32'(halted), 32'd1);
        chk("dual_hv",    {30'd0, ir0_valid, ir1_valid}, 32'd0);
        chk("dual_pcnt",  perf_dual, PERF ? 32'd4 : 32'd0);

        // Single issue leaves PC odd.
        reset_to_run();
        issue_cnt = 2'd1;
        tick();
        chk("odd_pc",   32'(pc), 32'd1);
        chk("odd_addr", 32'(Rom_addr_in), 32'd0);
        chk("odd_pc1",  32'(pc_1), 32'd1);
        chk("odd_sel0", 32'(sel_mem_0), 32'd2);
        chk("odd_sel1", 32'(sel_mem_1), 32'd0);

        // Stall holds the PC.
        issue_cnt = 2'd2; stall = 1'b1;
        tick();
        chk("stall_pc", 32'(pc), 32'd1);
        chk("stall_v",  {30'd0, ir0_valid, ir1_valid}, 32'd3);

        // A branch wins over stall and issue.
        br_taken = 1'b1; br_target = 15'd5;
        tick();
        chk("br_bubble", {30'd0, ir0_valid, ir1_valid}, 32'd0);
        chk("br_nohalt", 32'(halted), 32'd0);
        idle();
        tick();
        chk("br_pc",   32'(pc), 32'd5);
        chk("br_addr", 32'(Rom_addr_in), 32'd2);
        chk("br_v",    {30'd0, ir0_valid, ir1_valid}, 32'd3);
        chk("br_pbub", perf_bubble, PERF ? 32'd1 : 32'd0);

        // An illegal issue count of 3 leaves the PC unchanged.
        issue_cnt = 2'd3;
        tick(); chk("ic3_pc", 32'(pc), 32'd5);
        issue_cnt = 2'd2;
        tick();
        chk("end_pc7", 32'(pc), 32'd7);
        chk("end_v7",  {30'd0, ir0_valid, ir1_valid}, 32'd2);
        // Dual issue at PC 7 consumes only the one valid slot.
        tick();
        chk("end_pc8",  32'(pc), 32'd8);
        chk("end_halt", 32'(halted), 32'd1);
        chk("end_pdual", perf_dual, PERF ? 32'd1 : 32'd0);

        // Branch to a target outside the program halts directly.
        reset_to_run();
        br_taken = 1'b1; br_target = 15'd9;
        tick();
        chk("brout_halt", 32'(halted), 32'd1);
        chk("brout_pc",   32'(pc), 32'd0);

        // halt_req wins over br_taken; HALT ignores later requests until rst.
        reset_to_run();
        issue_cnt = 2'd1;
        tick();
        halt_req = 1'b1; br_taken = 1'b1; br_target = 15'd4;
        tick();
        chk("hr_halt", 32'(halted), 32'd1);
        chk("hr_pc",   32'(pc), 32'd1);
        idle();
        issue_cnt = 2'd2; br_taken = 1'b1; br_target = 15'd2;
        tick(); tick();
        chk("hr_frozen", 32'(pc), 32'd1);
        chk("hr_stay",   32'(halted), 32'd1);
        idle();
        rst = 1'b1;
        tick();
        chk("hrst_pc",   32'(pc), 32'd0);
        chk("hrst_halt", 32'(halted), 32'd0);
        chk("hrst_v",    {30'd0, ir0_valid, ir1_valid}, 32'd0);
        chk("hrst_pdual", perf_dual, 32'd0);
        rst = 1'b0;
        tick();
        chk("hrst_run", {30'd0, ir0_valid, ir1_valid}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
